// File: rtl/conv_maxpool.sv
// conv_maxpool: 2x2 stride-2 max-pool over a raster-order pixel stream using a half-width row buffer.
// Build option: define CONV_MAXPOOL_RELU_EN to clamp negative pooled values to zero.
module conv_maxpool #(
    parameter int N          = 2,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  running_o
);

    localparam int HALF = N / 2;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                       state_q;
    logic [CW-1:0]                col_q, row_q, col_d, row_d;
    logic signed [DATA_WIDTH-1:0] pair_q, data_q;
    logic                         valid_q, running_q;
    // Sized to the full index range so every index value selects a real entry.
    logic signed [DATA_WIDTH-1:0] rowbuf_q [0:(1<<IW)-1];

    logic                         accept, last_px;
    logic [IW-1:0]                idx;
    logic signed [DATA_WIDTH-1:0] h, pool, result;

    always_comb begin
        accept  = (state_q == RUN) && ena && valid_i;
        last_px = (col_q == CW'(N-1)) && (row_q == CW'(N-1));
        idx     = IW'(col_q >> 1);
        h       = ($signed(data_i) > pair_q) ? $signed(data_i) : pair_q;
        pool    = (rowbuf_q[idx] > h) ? rowbuf_q[idx] : h;
`ifdef CONV_MAXPOOL_RELU_EN
        result  = pool[DATA_WIDTH-1] ? '0 : pool;
`else
        result  = pool;
`endif
        col_d = col_q + 1'b1;
        row_d = row_q;
        if (col_q == CW'(N-1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            pair_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ena) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                        col_q     <= '0;
                        row_q     <= '0;
                    end
                end
                RUN: begin
                    if (!ena) begin
                        // abort: drop the partial frame, nothing more is emitted
                        state_q   <= IDLE;
                        running_q <= 1'b0;
                        col_q     <= '0;
                        row_q     <= '0;
                    end else if (valid_i) begin
                        col_q <= col_d;
                        row_q <= row_d;
                        if (!col_q[0]) begin
                            pair_q <= data_i;
                        end else if (row_q[0]) begin
                            data_q  <= result;
                            valid_q <= 1'b1;
                        end
                        if (last_px) begin
                            state_q   <= DONE;
                            running_q <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (!ena) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept && col_q[0] && !row_q[0]) rowbuf_q[idx] <= h;
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign running_o = running_q;

endmodule

// File: tb/tb_conv_maxpool.sv
// Self-checking bench for conv_maxpool (N=4): pooled outputs and strobe timing checked against a window-max model.
module tb_conv_maxpool;

    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int NPIX = N * N;
    localparam int NOUT = (N / 2) * (N / 2);

    logic          clk = 1'b0;
    logic          rst, ena, valid_i;
    logic [DW-1:0] data_i;
    logic [DW-1:0] data_o;
    logic          valid_o, running_o;

    conv_maxpool #(.N(N), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .running_o(running_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] obs_d[$];
    int            obs_c[$];
    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            obs_d.push_back(data_o);
            obs_c.push_back(cyc);
        end
    end

    int passed = 0;
    int total  = 0;

    logic [DW-1:0] px [NPIX];
    int            acc[NPIX];

    // Max over a 2x2 window of the frame, taken as signed values.
    function automatic logic signed [DW-1:0] ref_pool(input int pr, input int pc);
        logic signed [DW-1:0] m;
        logic signed [DW-1:0] v;
        m = $signed(px[(2*pr)*N + 2*pc]);
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
                v = $signed(px[(2*pr+dr)*N + 2*pc+dc]);
                if (v > m) m = v;
            end
`ifdef CONV_MAXPOOL_RELU_EN
        if (m < 0) m = '0;
`endif
        return m;
    endfunction

    task automatic present(input logic [DW-1:0] v);
        data_i  = v;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic junk(input int n);
        repeat (n) begin
            data_i  = DW'($urandom);
            valid_i = 1'b1;
            @(negedge clk);
        end
        valid_i = 1'b0;
    endtask

    // gap_mode: 0 back-to-back, 1 every-other-cycle plus 5-cycle gap after pixel 8, 2 random gaps
    task automatic run_frame(input string name, input int gap_mode);
        logic [DW-1:0] exp_d;
        int            exp_c;
        int            k;
        obs_d.delete();
        obs_c.delete();
        ena     = 1'b1;
        valid_i = 1'b0;
        @(negedge clk);
        total++;
        if (running_o !== 1'b1) $display("FAIL %s running_start: got %b want 1", name, running_o);
        else passed++;
        for (int i = 0; i < NPIX; i++) begin
            present(px[i]);
            acc[i] = cyc;
            if (i < NPIX - 1) begin
                if (gap_mode == 1) begin
                    idle(1);
                    if (i == 8) idle(5);
                end else if (gap_mode == 2) begin
                    idle($urandom_range(0, 2));
                end
            end
        end
        total++;
        if (running_o !== 1'b0) $display("FAIL %s running_end: got %b want 0", name, running_o);
        else passed++;
        junk(3);
        idle(1);
        total++;
        if (obs_d.size() != NOUT) $display("FAIL %s strobe_count: got %0d want %0d", name, obs_d.size(), NOUT);
        else passed++;
        k = 0;
        for (int pr = 0; pr < N/2; pr++)
            for (int pc = 0; pc < N/2; pc++) begin
                exp_d = ref_pool(pr, pc);
                exp_c = acc[(2*pr+1)*N + 2*pc+1];
                if (k < obs_d.size()) begin
                    total++;
                    if (obs_d[k] !== exp_d)
                        $display("FAIL %s out%0d_value: got %0d want %0d", name, k,
                                 $signed(obs_d[k]), $signed(exp_d));
                    else passed++;
                    total++;
                    if (obs_c[k] != exp_c)
                        $display("FAIL %s out%0d_cycle: got %0d want %0d", name, k, obs_c[k], exp_c);
                    else passed++;
                end
                k++;
            end
        total++;
        if (data_o !== exp_d) $display("FAIL %s data_hold: got %0d want %0d", name, $signed(data_o), $signed(exp_d));
        else passed++;
        total++;
        if (running_o !== 1'b0) $display("FAIL %s done_hold: got %b want 0", name, running_o);
        else passed++;
        obs_d.delete();
        obs_c.delete();
    endtask

    task automatic end_frame(input string name, input int n);
        ena = 1'b0;
        junk(n);
        total++;
        if (obs_d.size() != 0) $display("FAIL %s stray_strobe: got %0d want 0", name, obs_d.size());
        else passed++;
    endtask

    task automatic load_ramp(input int start, input int step);
        for (int i = 0; i < NPIX; i++) px[i] = DW'(start + step * i);
    endtask

    task automatic test_reset;
        #1;
        total++;
        if (data_o !== '0) $display("FAIL reset_data: got %0d want 0", data_o);
        else passed++;
        total++;
        if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o);
        else passed++;
        total++;
        if (running_o !== 1'b0) $display("FAIL reset_running: got %b want 0", running_o);
        else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(2);
    endtask

    task automatic test_basic;
        load_ramp(0, 1);
        run_frame("basic", 0);
        end_frame("basic", 2);
    endtask

    task automatic test_signed;
        load_ramp(-16, 1);
        run_frame("signed", 0);
        end_frame("signed", 2);
    endtask

    task automatic test_stalls;
        load_ramp(0, 1);
        run_frame("stalls", 1);
        end_frame("stalls", 2);
    endtask

    task automatic test_restart;
        load_ramp(0, 1);
        run_frame("restart_a", 0);
        end_frame("restart_gap", 2);
        load_ramp(15, -1);
        run_frame("restart_b", 0);
        end_frame("restart_b", 2);
    endtask

    task automatic test_async_reset;
        load_ramp(0, 1);
        ena = 1'b1;
        @(negedge clk);
        for (int i = 0; i <= 9; i++) present(px[i]);
        rst = 1'b0;
        #1;
        obs_d.delete();
        obs_c.delete();
        total++;
        if (data_o !== '0) $display("FAIL midreset_data: got %0d want 0", data_o);
        else passed++;
        total++;
        if (running_o !== 1'b0) $display("FAIL midreset_running: got %b want 0", running_o);
        else passed++;
        ena = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        end_frame("post_reset", 2);
        run_frame("after_reset", 0);
        end_frame("after_reset", 2);
    endtask

    task automatic test_abort;
        load_ramp(0, 1);
        ena = 1'b1;
        @(negedge clk);
        for (int i = 0; i <= 6; i++) present(px[i]);
        ena = 1'b0;
        @(negedge clk);
        total++;
        if (running_o !== 1'b0) $display("FAIL abort_running: got %b want 0", running_o);
        else passed++;
        obs_d.delete();
        obs_c.delete();
        end_frame("abort_gap", 2);
        run_frame("after_abort", 0);
        end_frame("after_abort", 2);
    endtask

    task automatic test_random;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NPIX; i++) px[i] = DW'($urandom);
            run_frame("random", 2);
            end_frame("random", 2);
        end
    endtask

    initial begin
        rst     = 1'b0;
        ena     = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        test_reset();
        test_basic();
        test_signed();
        test_stalls();
        test_restart();
        test_async_reset();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
